// File: rtl/keycode_pkg.sv
// Shared types and HID constants for the keycode event decoder.
package keycode_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        JUMP  = 2'd2,
        RUN   = 2'd3
    } action_e;

    localparam logic [7:0] HID_EMPTY    = 8'h00;
    localparam logic [7:0] HID_ROLLOVER = 8'h01;
    localparam logic [7:0] HID_SPACE    = 8'h2C;
    localparam int         NUM_SLOTS    = 4;

    typedef struct packed {
        logic    is_press;
        action_e id;
    } key_evt_t;

    // True when any non-empty slot of the keycode word carries the given usage code.
    function automatic logic slot_match(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (kc[8*s +: 8] == code && kc[8*s +: 8] != HID_EMPTY) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/keycode_event_decoder_if.sv
// Valid/ready event stream carrying {is_press, action_id} from the decoder to the game logic.
interface keycode_event_decoder_if;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       evt_ready;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/keycode_evt_fifo.sv
// Synchronous FIFO of key events; pointers carry one extra wrap bit to tell full from empty.
module keycode_evt_fifo
    import keycode_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = key_evt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        wr_en, rd_en;
    T            mem_q [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop & ~empty;
    // A pop frees a slot in the same cycle, so a push while full still lands.
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = wr_q + PTR_ONE;
        if (rd_en) rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign head = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/keycode_event_decoder.sv
// Frame-sampled HID keycode to game-action decoder with press/release event FIFO.
// Optional build macro: KEYCODE_DEBOUNCE_EN (two agreeing frames required to change a held bit).
module keycode_event_decoder
    import keycode_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07,
    parameter logic [7:0] KEY_JUMP   = 8'h1A,
    parameter logic [7:0] KEY_RUN    = 8'h0D
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [31:0] keycode,
    output logic [3:0]  held,
    output logic [3:0]  pressed,
    output logic [3:0]  released,
    output logic        overflow,
    keycode_event_decoder_if.master evt
);
    typedef enum logic {IDLE, SCAN} state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       frame_q, frame_d;
    logic       pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic [3:0] held_q, held_d, pressed_q, pressed_d, released_q, released_d;
    logic [3:0] chg_q, chg_d, new_q, new_d;
    logic [3:0] raw, target;
    logic       tick, rollover, push, drop;
    logic       fifo_full, fifo_empty;
    key_evt_t   push_evt, fifo_head;

    assign tick     = frame_clk & ~frame_q;
    assign frame_d  = frame_clk;
    assign rollover = slot_match(keycode, HID_ROLLOVER);
    assign raw[0]   = slot_match(keycode, KEY_LEFT);
    assign raw[1]   = slot_match(keycode, KEY_RIGHT);
    assign raw[2]   = slot_match(keycode, KEY_JUMP) | slot_match(keycode, HID_SPACE);
    assign raw[3]   = slot_match(keycode, KEY_RUN);

`ifdef KEYCODE_DEBOUNCE_EN
    logic [3:0] prev_q, prev_d;
    // A bit moves only when this sample agrees with the previous valid sample.
    assign target = (~(raw ^ prev_q) & raw) | ((raw ^ prev_q) & held_q);
`else
    assign target = raw;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        held_d     = held_q;
        pressed_d  = 4'b0000;
        released_d = 4'b0000;
        chg_d      = chg_q;
        new_d      = new_q;
        push       = 1'b0;
        push_evt   = '0;
`ifdef KEYCODE_DEBOUNCE_EN
        prev_d     = prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                    if (!rollover) begin
`ifdef KEYCODE_DEBOUNCE_EN
                        prev_d     = raw;
`endif
                        held_d     = target;
                        pressed_d  = target & ~held_q;
                        released_d = held_q & ~target;
                        chg_d      = held_q ^ target;
                        new_d      = target;
                        idx_d      = 2'd0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                if (tick) pending_d = 1'b1;
                push              = chg_q[idx_q];
                push_evt.is_press = new_q[idx_q];
                push_evt.id       = action_e'(idx_q);
                idx_d             = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop       = push & fifo_full & ~(evt.evt_ready & ~fifo_empty);
    assign overflow_d = overflow_q | drop;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            frame_q    <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            held_q     <= 4'b0000;
            pressed_q  <= 4'b0000;
            released_q <= 4'b0000;
            chg_q      <= 4'b0000;
            new_q      <= 4'b0000;
`ifdef KEYCODE_DEBOUNCE_EN
            prev_q     <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            held_q     <= held_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            chg_q      <= chg_d;
            new_q      <= new_d;
`ifdef KEYCODE_DEBOUNCE_EN
            prev_q     <= prev_d;
`endif
        end
    end

    keycode_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (key_evt_t)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt.evt_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign held          = held_q;
    assign pressed       = pressed_q;
    assign released      = released_q;
    assign overflow      = overflow_q;
    assign evt.evt_valid = ~fifo_empty;
    // Stale RAM contents are masked so the data bus reads zero whenever nothing is queued.
    assign evt.evt_data  = fifo_empty ? 3'b000 : fifo_head;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Randomised bench for keycode_event_decoder against a frame-level behavioural model.
module tb_keycode_event_decoder;
    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [31:0] keycode = 32'h0;
    logic [3:0]  held, pressed, released;
    logic        overflow;

    keycode_event_decoder_if evt ();

    keycode_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .held      (held),
        .pressed   (pressed),
        .released  (released),
        .overflow  (overflow),
        .evt       (evt)
    );

    always #10 Clk = ~Clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    logic [3:0] m_held  = 4'b0;
    logic [3:0] m_press = 4'b0;
    logic [3:0] m_rel   = 4'b0;
    logic       m_ovf   = 1'b0;
`ifdef KEYCODE_DEBOUNCE_EN
    logic [3:0] m_last  = 4'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] key_actions(input logic [31:0] kc);
        logic [3:0] r;
        r = 4'b0;
        for (int s = 0; s < 4; s++) begin
            case (kc[8*s +: 8])
                8'h04:        r[0] = 1'b1;
                8'h07:        r[1] = 1'b1;
                8'h1A, 8'h2C: r[2] = 1'b1;
                8'h0D:        r[3] = 1'b1;
                default:      ;
            endcase
        end
        return r;
    endfunction

    function automatic logic has_rollover(input logic [31:0] kc);
        logic r;
        r = 1'b0;
        for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == 8'h01) r = 1'b1;
        return r;
    endfunction

    // One serviced frame: new held state, pulses, and ascending-order events into the queue.
    task automatic model_frame(input logic [31:0] kc);
        logic [3:0] raw, tgt;
        m_press = 4'b0;
        m_rel   = 4'b0;
        if (has_rollover(kc)) return;
        raw = key_actions(kc);
`ifdef KEYCODE_DEBOUNCE_EN
        for (int a = 0; a < 4; a++) tgt[a] = (raw[a] == m_last[a]) ? raw[a] : m_held[a];
        m_last = raw;
`else
        tgt = raw;
`endif
        for (int a = 0; a < 4; a++) begin
            if (tgt[a] != m_held[a]) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({tgt[a], 2'(a)});
                else m_ovf = 1'b1;
            end
        end
        m_press = tgt & ~m_held;
        m_rel   = m_held & ~tgt;
        m_held  = tgt;
    endtask

    task automatic do_frame(input logic [31:0] kc);
        @(negedge Clk);
        keycode   = kc;
        frame_clk = 1'b1;
        model_frame(kc);
        @(negedge Clk);
        frame_clk = 1'b0;
        check_eq("held", held, m_held);
        check_eq("pressed", pressed, m_press);
        check_eq("released", released, m_rel);
        repeat (7) @(negedge Clk);
        check_eq("pulse_clear", pressed | released, 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("evt_valid", evt.evt_valid, exp_q.size() != 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || evt.evt_valid) && guard < 200) begin
            @(negedge Clk);
            evt.evt_ready = 1'($urandom_range(0, 1));
            if (evt.evt_ready && evt.evt_valid) begin
                if (exp_q.size() == 0) check_eq("evt_extra", evt.evt_data, 3'bx);
                else check_eq("evt_data", evt.evt_data, exp_q.pop_front());
            end
            guard++;
        end
        @(negedge Clk);
        evt.evt_ready = 1'b0;
        check_eq("drain_timeout", guard >= 200, 0);
        check_eq("drain_empty", evt.evt_valid, 0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_held = 4'b0;
        m_ovf  = 1'b0;
`ifdef KEYCODE_DEBOUNCE_EN
        m_last = 4'b0;
`endif
    endtask

    initial begin
        logic [7:0]  pool [16];
        logic [31:0] kc;
        pool = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h07, 8'h1A, 8'h2C, 8'h0D,
                 8'h04, 8'h07, 8'h1A, 8'h0D, 8'h01, 8'h05, 8'h2C, 8'h00};
        evt.evt_ready = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("rst_held", held, 0);
        check_eq("rst_pulses", pressed | released, 0);
        check_eq("rst_valid", evt.evt_valid, 0);
        check_eq("rst_overflow", overflow, 0);
        Reset = 1'b0;

        // Single LEFT press, then mixed release/press, then rollover
        do_frame(32'h0000_0004);
`ifdef KEYCODE_DEBOUNCE_EN
        do_frame(32'h0000_0004);
`endif
        drain();
        do_frame(32'h0000_1A07);
`ifdef KEYCODE_DEBOUNCE_EN
        do_frame(32'h0000_1A07);
`endif
        drain();
        do_frame(32'h0001_0004);
        drain();

        // Overflow: LEFT toggled nine times with the consumer stalled
        do_frame(32'h0);
        do_frame(32'h0);
        drain();
        for (int i = 0; i < 9; i++) begin
            do_frame((i % 2 == 0) ? 32'h0000_0004 : 32'h0);
`ifdef KEYCODE_DEBOUNCE_EN
            do_frame((i % 2 == 0) ? 32'h0000_0004 : 32'h0);
`endif
        end
        check_eq("ovf_set", overflow, 1);
        drain();

        // Second tick during SCAN is serviced with the later keycode
        @(negedge Clk);
        keycode = 32'h0000_0D04; frame_clk = 1'b1;
        model_frame(32'h0000_0D04);
        @(negedge Clk); frame_clk = 1'b0;
        @(negedge Clk);
        keycode = 32'h2C00_0007; frame_clk = 1'b1;
        model_frame(32'h2C00_0007);
        @(negedge Clk); frame_clk = 1'b0;
        repeat (14) @(negedge Clk);
        check_eq("pend_held", held, m_held);
        drain();

        // Single-frame RIGHT glitch then a two-frame RIGHT hold
        do_frame(32'h0);
        do_frame(32'h0);
        drain();
        do_frame(32'h0000_0007);
        do_frame(32'h0);
        do_frame(32'h0);
        drain();
        do_frame(32'h0000_0007);
        do_frame(32'h0000_0007);
        drain();

        // Random keycodes
        for (int i = 0; i < 30; i++) begin
            kc = 32'h0;
            for (int s = 0; s < 4; s++) kc[8*s +: 8] = pool[$urandom_range(0, 15)];
            do_frame(kc);
            if ($urandom_range(0, 2) == 0 || exp_q.size() > 4) drain();
        end
        drain();

        // Asynchronous reset while SCAN is pushing events
        do_frame(32'h0);
        do_frame(32'h0);
        drain();
`ifdef KEYCODE_DEBOUNCE_EN
        do_frame(32'h0D1A_0704);
        drain();
        do_frame(32'h0);
        drain();
        do_frame(32'h0D1A_0704);
        drain();
`endif
        @(negedge Clk);
        keycode = 32'h0D1A_0704; frame_clk = 1'b1;
        model_frame(32'h0D1A_0704);
        @(negedge Clk); frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("pre_rst_valid", evt.evt_valid, 1);
        Reset = 1'b1;
        #1;
        check_eq("mid_rst_held", held, 0);
        check_eq("mid_rst_pulses", pressed | released, 0);
        check_eq("mid_rst_valid", evt.evt_valid, 0);
        check_eq("mid_rst_data", evt.evt_data, 0);
        check_eq("mid_rst_overflow", overflow, 0);
        reset_model();
        keycode = 32'h0;
        @(negedge Clk);
        Reset = 1'b0;
        do_frame(32'h0000_0D00);
`ifdef KEYCODE_DEBOUNCE_EN
        do_frame(32'h0000_0D00);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
